// File: rtl/hdu_scoreboard_pkg.sv
// Shared types and constants for the Alioth decode-stage hazard scoreboard.
package alioth_hdu_pkg;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         DEPTH_MIN = 2;
    localparam int         DEPTH_MAX = 16;

    // One in-flight register write; the tag is the entry's index.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_entry_t;

    function automatic bit depth_ok(input int d);
        return (d >= DEPTH_MIN) && (d <= DEPTH_MAX);
    endfunction

endpackage

// File: rtl/hdu_scoreboard_free_alloc.sv
// Find-first-zero priority encoder over the scoreboard valid vector.
// Returns the lowest free index (0 when none is free) plus an any-free flag.
module hdu_free_alloc
    import alioth_hdu_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any_free
);

    // Scan high to low so the lowest free index wins.
    always_comb begin
        o_idx      = '0;
        o_any_free = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!i_valid[i]) begin
                o_idx      = IDX_W'(i);
                o_any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hdu_scoreboard.sv
// Tagged hazard-detection scoreboard for the decode stage.
// Tracks DEPTH in-flight register writes that may retire out of order and
// stalls decode on uncovered RAW hazards or scoreboard exhaustion.
// Optional WAW stall is compiled in with `define HDU_WAW_CHECK_EN.
module hdu_scoreboard
    import alioth_hdu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int TAG_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic             access_rs1,
    input  logic             access_rs2,
    input  logic [4:0]       rd,
    input  logic             reg_we,
    input  logic             ex_reg_we,
    input  logic [4:0]       ex_reg_waddr,
    input  logic             wb_done,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic             flush,
    output logic             hold_flag,
    output logic             issue_fire,
    output logic [TAG_W-1:0] issue_tag,
    output logic             sb_full,
    output logic [CNT_W-1:0] pending_cnt
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("hdu_scoreboard: DEPTH out of range 2..16");
    end

    sb_entry_t        r_sb [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_retiring;
    logic [DEPTH-1:0] w_hit_rs1;
    logic [DEPTH-1:0] w_hit_rs2;
    logic [DEPTH-1:0] w_hit_rd;
    logic [TAG_W-1:0] w_free_idx;
    logic             w_any_free;
    logic             w_needs_entry;
    logic             w_raw_rs1;
    logic             w_raw_rs2;
    logic             w_waw;

    // Per-entry decode: live entries (valid and not retiring now) raise hits.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i]    = r_sb[i].valid;
            w_retiring[i] = wb_done && (wb_tag == TAG_W'(i)) && r_sb[i].valid;
            w_hit_rs1[i]  = r_sb[i].valid && !w_retiring[i] && (r_sb[i].rd == rs1);
            w_hit_rs2[i]  = r_sb[i].valid && !w_retiring[i] && (r_sb[i].rd == rs2);
            w_hit_rd[i]   = r_sb[i].valid && !w_retiring[i] && (r_sb[i].rd == rd);
        end
    end

    hdu_free_alloc #(
        .N     (DEPTH),
        .IDX_W (TAG_W)
    ) u_free_alloc (
        .i_valid    (w_valid),
        .o_idx      (w_free_idx),
        .o_any_free (w_any_free)
    );

    assign w_needs_entry = inst_valid && reg_we && (rd != REG_ZERO);

    // A pending write to a source stalls unless EX can forward that register.
    assign w_raw_rs1 = access_rs1 && (rs1 != REG_ZERO) && (|w_hit_rs1)
                       && !(ex_reg_we && (ex_reg_waddr == rs1));
    assign w_raw_rs2 = access_rs2 && (rs2 != REG_ZERO) && (|w_hit_rs2)
                       && !(ex_reg_we && (ex_reg_waddr == rs2));

`ifdef HDU_WAW_CHECK_EN
    assign w_waw = w_needs_entry && (|w_hit_rd);
`else
    // Duplicate rd entries are legal; RAW holds until every copy retires.
    assign w_waw = 1'b0 & (|w_hit_rd);
`endif

    assign sb_full     = !w_any_free;
    assign hold_flag   = inst_valid && !flush &&
                         (w_raw_rs1 || w_raw_rs2 || w_waw || (w_needs_entry && sb_full));
    assign issue_fire  = w_needs_entry && !hold_flag && !flush;
    assign issue_tag   = w_free_idx;

    // Occupancy is a popcount of the valid vector, so it can never drift.
    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_cnt = pending_cnt + CNT_W'(w_valid[i]);
        end
    end

    // Entry update: flush beats retire/allocate; a retiring slot is not
    // free this cycle, so retire and allocate never target the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sb[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sb[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_retiring[i]) begin
                    r_sb[i].valid <= 1'b0;
                end else if (issue_fire && (w_free_idx == TAG_W'(i))) begin
                    r_sb[i].valid <= 1'b1;
                    r_sb[i].rd    <= rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_hdu_scoreboard.sv
// Self-checking bench for hdu_scoreboard (DEPTH=4): directed scenarios plus
// randomized traffic against a queue-of-pending-writes reference model.
module tb_hdu_scoreboard;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             inst_valid, access_rs1, access_rs2, reg_we;
    logic [4:0]       rs1, rs2, rd, ex_reg_waddr;
    logic             ex_reg_we, wb_done, flush;
    logic [TAG_W-1:0] wb_tag;
    logic             hold_flag, issue_fire, sb_full;
    logic [TAG_W-1:0] issue_tag;
    logic [CNT_W-1:0] pending_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct { int tag; int rd; } pend_t;
    pend_t pend[$];

    always #5 clk = ~clk;

    hdu_scoreboard #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid),
        .rs1(rs1), .rs2(rs2), .access_rs1(access_rs1), .access_rs2(access_rs2),
        .rd(rd), .reg_we(reg_we), .ex_reg_we(ex_reg_we), .ex_reg_waddr(ex_reg_waddr),
        .wb_done(wb_done), .wb_tag(wb_tag), .flush(flush),
        .hold_flag(hold_flag), .issue_fire(issue_fire), .issue_tag(issue_tag),
        .sb_full(sb_full), .pending_cnt(pending_cnt)
    );

    // ---------------- reference model ----------------
    function automatic bit m_pending_rd(int r);
        foreach (pend[k])
            if (pend[k].rd == r && !(wb_done && int'(wb_tag) == pend[k].tag)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_raw(int s, bit acc);
        if (!acc || s == 0) return 1'b0;
        if (ex_reg_we && int'(ex_reg_waddr) == s) return 1'b0;
        return m_pending_rd(s);
    endfunction

    function automatic int m_free();
        for (int t = 0; t < DEPTH; t++) begin
            bit used = 1'b0;
            foreach (pend[k]) if (pend[k].tag == t) used = 1'b1;
            if (!used) return t;
        end
        return -1;
    endfunction

    function automatic bit m_needs();
        return inst_valid && reg_we && rd != 0;
    endfunction

    function automatic bit m_hold();
        bit waw = 1'b0;
`ifdef HDU_WAW_CHECK_EN
        waw = m_needs() && m_pending_rd(int'(rd));
`endif
        return inst_valid && !flush &&
               (m_raw(int'(rs1), access_rs1) || m_raw(int'(rs2), access_rs2) || waw ||
                (m_needs() && pend.size() == DEPTH));
    endfunction

    function automatic bit m_fire();
        return m_needs() && !m_hold() && !flush;
    endfunction

    function automatic int m_tag();
        int f = m_free();
        return (f < 0) ? 0 : f;
    endfunction

    // Advance the model with the inputs present at the coming edge.
    task automatic m_step();
        bit fire = m_fire();
        int tag  = m_free();
        if (flush) begin
            pend.delete();
        end else begin
            if (wb_done) begin
                int idx = -1;
                foreach (pend[k]) if (pend[k].tag == int'(wb_tag)) idx = k;
                if (idx >= 0) pend.delete(idx);
            end
            if (fire) pend.push_back('{tag: tag, rd: int'(rd)});
        end
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_valid = 0; access_rs1 = 0; access_rs2 = 0; reg_we = 0;
        rs1 = 0; rs2 = 0; rd = 0; ex_reg_we = 0; ex_reg_waddr = 0;
        wb_done = 0; wb_tag = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        pend.delete();
        #1;
    endtask

    task automatic alloc(input logic [4:0] r);
        idle();
        inst_valid = 1; reg_we = 1; rd = r;
        tick();
        idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst = 1'b1;
        inst_valid = 1; rs1 = 5; access_rs1 = 1; reg_we = 1; rd = 3;
        #2;
        checks++; if (hold_flag !== 1'b0) begin errors++; $display("FAIL reset_hold got=%b exp=0", hold_flag); end
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", pending_cnt); end
        checks++; if (sb_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", sb_full); end
        checks++; if (issue_tag !== 2'd0) begin errors++; $display("FAIL reset_tag got=%0d exp=0", issue_tag); end
        checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL reset_fire got=%b exp=1", issue_fire); end
        @(posedge clk); #1;
        rst = 1'b0;
        pend.delete();
        idle();
    endtask

    task automatic test_raw_ooo();
        do_reset();
        inst_valid = 1; reg_we = 1; rd = 5; #1;
        checks++; if (issue_tag !== 2'd0 || issue_fire !== 1'b1) begin errors++; $display("FAIL raw_issue0 tag=%0d fire=%b exp tag=0 fire=1", issue_tag, issue_fire); end
        tick();
        rd = 6; #1;
        checks++; if (issue_tag !== 2'd1 || issue_fire !== 1'b1) begin errors++; $display("FAIL raw_issue1 tag=%0d fire=%b exp tag=1 fire=1", issue_tag, issue_fire); end
        tick();
        idle();
        inst_valid = 1; rs1 = 5; access_rs1 = 1; #1;
        checks++; if (hold_flag !== 1'b1) begin errors++; $display("FAIL raw_hold got=%b exp=1", hold_flag); end
        wb_done = 1; wb_tag = 1; #1;
        checks++; if (hold_flag !== 1'b1) begin errors++; $display("FAIL raw_hold_other_retire got=%b exp=1", hold_flag); end
        tick();
        wb_tag = 0; #1;
        checks++; if (hold_flag !== 1'b0) begin errors++; $display("FAIL raw_same_cycle_wb got=%b exp=0", hold_flag); end
        tick();
        idle(); #1;
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL raw_drain_cnt got=%0d exp=0", pending_cnt); end
    endtask

    task automatic test_forwarding();
        do_reset();
        alloc(5'd7);
        inst_valid = 1; rs2 = 7; access_rs2 = 1; ex_reg_we = 1; ex_reg_waddr = 7; #1;
        checks++; if (hold_flag !== 1'b0) begin errors++; $display("FAIL fwd_ex_cover got=%b exp=0", hold_flag); end
        ex_reg_we = 0; #1;
        checks++; if (hold_flag !== 1'b1) begin errors++; $display("FAIL fwd_no_ex got=%b exp=1", hold_flag); end
        access_rs2 = 0; #1;
        checks++; if (hold_flag !== 1'b0) begin errors++; $display("FAIL fwd_no_access got=%b exp=0", hold_flag); end
        idle();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            inst_valid = 1; reg_we = 1; rd = 5'(i); #1;
            checks++; if (issue_tag !== 2'(i - 1)) begin errors++; $display("FAIL full_alloc_tag got=%0d exp=%0d", issue_tag, i - 1); end
            tick();
        end
        idle(); #1;
        checks++; if (sb_full !== 1'b1 || pending_cnt !== 3'd4) begin errors++; $display("FAIL full_state full=%b cnt=%0d exp full=1 cnt=4", sb_full, pending_cnt); end
        checks++; if (issue_tag !== 2'd0) begin errors++; $display("FAIL full_tag got=%0d exp=0", issue_tag); end
        inst_valid = 1; reg_we = 1; rd = 8; #1;
        checks++; if (hold_flag !== 1'b1 || issue_fire !== 1'b0) begin errors++; $display("FAIL full_fifth hold=%b fire=%b exp hold=1 fire=0", hold_flag, issue_fire); end
        wb_done = 1; wb_tag = 2; #1;
        checks++; if (hold_flag !== 1'b1 || issue_fire !== 1'b0) begin errors++; $display("FAIL full_retire_noreuse hold=%b fire=%b exp hold=1 fire=0", hold_flag, issue_fire); end
        tick();
        wb_done = 0; #1;
        checks++; if (issue_fire !== 1'b1 || issue_tag !== 2'd2) begin errors++; $display("FAIL full_realloc fire=%b tag=%0d exp fire=1 tag=2", issue_fire, issue_tag); end
        tick();
        idle(); #1;
        checks++; if (pending_cnt !== 3'd4) begin errors++; $display("FAIL full_refill_cnt got=%0d exp=4", pending_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc(5'd1); alloc(5'd2); alloc(5'd3);
        inst_valid = 1; reg_we = 1; rd = 10; flush = 1; wb_done = 1; wb_tag = 0; #1;
        checks++; if (issue_fire !== 1'b0 || hold_flag !== 1'b0) begin errors++; $display("FAIL flush_fire fire=%b hold=%b exp 0 0", issue_fire, hold_flag); end
        tick();
        idle(); #1;
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL flush_cnt got=%0d exp=0", pending_cnt); end
        wb_done = 1; wb_tag = 1;
        tick();
        idle(); #1;
        checks++; if (pending_cnt !== 3'd0 || sb_full !== 1'b0) begin errors++; $display("FAIL flush_late_wb cnt=%0d full=%b exp 0 0", pending_cnt, sb_full); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc(5'd4); alloc(5'd11);
        rst = 1'b1; #2;
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", pending_cnt); end
        rst = 1'b0; pend.delete();
        wb_done = 1; wb_tag = 1;
        tick();
        idle(); #1;
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL midrst_late_wb got=%0d exp=0", pending_cnt); end
        inst_valid = 1; rs1 = 4; access_rs1 = 1; #1;
        checks++; if (hold_flag !== 1'b0) begin errors++; $display("FAIL midrst_no_raw got=%b exp=0", hold_flag); end
        idle();
    endtask

    task automatic test_waw();
        do_reset();
        alloc(5'd9);
        inst_valid = 1; reg_we = 1; rd = 9; #1;
`ifdef HDU_WAW_CHECK_EN
        checks++; if (hold_flag !== 1'b1 || issue_fire !== 1'b0) begin errors++; $display("FAIL waw_hold hold=%b fire=%b exp 1 0", hold_flag, issue_fire); end
        tick();
        idle(); #1;
        checks++; if (pending_cnt !== 3'd1) begin errors++; $display("FAIL waw_cnt got=%0d exp=1", pending_cnt); end
`else
        checks++; if (issue_fire !== 1'b1 || issue_tag !== 2'd1) begin errors++; $display("FAIL waw_dup_fire fire=%b tag=%0d exp 1 1", issue_fire, issue_tag); end
        tick();
        idle(); #1;
        checks++; if (pending_cnt !== 3'd2) begin errors++; $display("FAIL waw_dup_cnt got=%0d exp=2", pending_cnt); end
        // Retire one copy: the other still raises RAW.
        inst_valid = 1; rs1 = 9; access_rs1 = 1; wb_done = 1; wb_tag = 0; #1;
        checks++; if (hold_flag !== 1'b1) begin errors++; $display("FAIL waw_dup_raw got=%b exp=1", hold_flag); end
        tick();
        idle();
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            inst_valid   = ($urandom % 4) != 0;
            rs1          = 5'($urandom % 8);
            rs2          = 5'($urandom % 8);
            access_rs1   = 1'($urandom);
            access_rs2   = 1'($urandom);
            rd           = 5'($urandom % 8);
            reg_we       = ($urandom % 4) != 0;
            ex_reg_we    = ($urandom % 4) == 0;
            ex_reg_waddr = 5'($urandom % 8);
            flush        = ($urandom % 25) == 0;
            wb_done      = ($urandom % 2) == 0;
            if (pend.size() > 0 && ($urandom % 4) != 0)
                wb_tag = 2'(pend[$urandom % pend.size()].tag);
            else
                wb_tag = 2'($urandom);
            #1;
            checks++; if (hold_flag !== m_hold()) begin errors++; $display("FAIL rnd_hold cyc=%0d got=%b exp=%b", c, hold_flag, m_hold()); end
            checks++; if (issue_fire !== m_fire()) begin errors++; $display("FAIL rnd_fire cyc=%0d got=%b exp=%b", c, issue_fire, m_fire()); end
            checks++; if (issue_tag !== 2'(m_tag())) begin errors++; $display("FAIL rnd_tag cyc=%0d got=%0d exp=%0d", c, issue_tag, m_tag()); end
            checks++; if (sb_full !== (pend.size() == DEPTH)) begin errors++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", c, sb_full, pend.size() == DEPTH); end
            checks++; if (pending_cnt !== 3'(pend.size())) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, pending_cnt, pend.size()); end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_raw_ooo();
        test_forwarding();
        test_full();
        test_flush();
        test_reset_mid();
        test_waw();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
